// File: rtl/dtcm_arbiter_pkg.sv
// Shared DTCM sizing constants, arbiter state encodings and the round-robin pick helper.
package dtcm_arbiter_pkg;

    localparam int DTCM_ADDR_WIDTH = 16;
    localparam int DTCM_RAM_DW     = 32;
    localparam int DTCM_RAM_MW     = DTCM_RAM_DW / 8;

    // Arbiter FSM encodings, kept as plain constants for compatibility with older tooling.
    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_LOCK = 1'b1;

    // Requester identifiers carried in the outstanding-ID FIFO.
    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    // Favoured requester wins when valid, otherwise the other one if valid.
    // With nobody valid the favoured requester is returned (harmless, nothing handshakes).
    function automatic logic rr_pick(input logic ptr, input logic v0, input logic v1);
        logic win;
        if (ptr == REQ_M0) win = v0 ? REQ_M0 : (v1 ? REQ_M1 : REQ_M0);
        else               win = v1 ? REQ_M1 : (v0 ? REQ_M0 : REQ_M1);
        return win;
    endfunction

endpackage

// File: rtl/dtcm_arbiter_id_fifo.sv
// arb_id_fifo: 1-bit wide synchronous FIFO recording which requester owns each
// outstanding DTCM command, so in-order responses can be steered back.
module arb_id_fifo #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          din_i,
    output logic          head_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Storage write on push.
    // NOTE: the ID storage has no reset; count/pointers gate every read, so stale entries are never observed.
    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    // Next-state for pointers and occupancy; push and pop together leave count unchanged.
    // NOTE: every output gets a default first so no path leaves a signal unassigned (no latch).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/dtcm_arbiter.sv
// dtcm_arbiter: two-requester round-robin arbiter in front of dtcm_ctrl.
// Commands pass through combinationally; responses return in order and are
// steered by the ID FIFO of outstanding commands.
module dtcm_arbiter
    import dtcm_arbiter_pkg::*;
#(
    parameter int AW         = DTCM_ADDR_WIDTH,
    parameter int DW         = DTCM_RAM_DW,
    parameter int MW         = DTCM_RAM_MW,
    parameter int OUTS_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_cmd_valid,
    output logic          m0_cmd_ready,
    input  logic          m0_cmd_read,
    input  logic [AW-1:0] m0_cmd_addr,
    input  logic [DW-1:0] m0_cmd_wdata,
    input  logic [MW-1:0] m0_cmd_wmask,
    output logic          m0_rsp_valid,
    input  logic          m0_rsp_ready,
    output logic [DW-1:0] m0_rsp_rdata,
    input  logic          m1_cmd_valid,
    output logic          m1_cmd_ready,
    input  logic          m1_cmd_read,
    input  logic [AW-1:0] m1_cmd_addr,
    input  logic [DW-1:0] m1_cmd_wdata,
    input  logic [MW-1:0] m1_cmd_wmask,
    output logic          m1_rsp_valid,
    input  logic          m1_rsp_ready,
    output logic [DW-1:0] m1_rsp_rdata,
    output logic          s_cmd_valid,
    input  logic          s_cmd_ready,
    output logic          s_cmd_read,
    output logic [AW-1:0] s_cmd_addr,
    output logic [DW-1:0] s_cmd_wdata,
    output logic [MW-1:0] s_cmd_wmask,
    input  logic          s_rsp_valid,
    output logic          s_rsp_ready,
    input  logic [DW-1:0] s_rsp_rdata,
    output logic          rsp_err
);

    localparam int CW = $clog2(OUTS_DEPTH + 1);

    logic [0:0]    state_q, state_d;
    logic          grant_q, grant_d;
    logic          rr_q, rr_d;
    logic          err_q, err_d;
    logic          grant;
    logic          req_valid;
    logic          cmd_hs;
    logic          rsp_pop;
    logic          fifo_full, fifo_empty, fifo_head;
    logic [CW-1:0] id_count;

    // Command path: in LOCK the registered grant is held, otherwise arbitrate this cycle.
    assign grant     = (state_q == ARB_LOCK) ? grant_q : rr_pick(rr_q, m0_cmd_valid, m1_cmd_valid);
    assign req_valid = grant ? m1_cmd_valid : m0_cmd_valid;

    // A full FIFO blocks commands even if a pop happens this cycle, keeping rsp off the cmd path.
    assign s_cmd_valid  = req_valid && !fifo_full;
    assign s_cmd_read   = grant ? m1_cmd_read  : m0_cmd_read;
    assign s_cmd_addr   = grant ? m1_cmd_addr  : m0_cmd_addr;
    assign s_cmd_wdata  = grant ? m1_cmd_wdata : m0_cmd_wdata;
    assign s_cmd_wmask  = grant ? m1_cmd_wmask : m0_cmd_wmask;
    assign m0_cmd_ready = s_cmd_ready && (grant == REQ_M0) && !fifo_full;
    assign m1_cmd_ready = s_cmd_ready && (grant == REQ_M1) && !fifo_full;
    assign cmd_hs       = s_cmd_valid && s_cmd_ready;

    // Response path: steer by FIFO head; with nothing outstanding a response is swallowed.
    assign m0_rsp_valid = s_rsp_valid && !fifo_empty && (fifo_head == REQ_M0);
    assign m1_rsp_valid = s_rsp_valid && !fifo_empty && (fifo_head == REQ_M1);
    assign s_rsp_ready  = fifo_empty ? s_rsp_valid : (fifo_head ? m1_rsp_ready : m0_rsp_ready);
    assign rsp_pop      = s_rsp_valid && s_rsp_ready && !fifo_empty;
    assign m0_rsp_rdata = s_rsp_rdata;
    assign m1_rsp_rdata = s_rsp_rdata;
    assign rsp_err      = err_q;

    arb_id_fifo #(
        .DEPTH (OUTS_DEPTH)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_hs),
        .pop_i   (rsp_pop),
        .din_i   (grant),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (id_count)
    );

    // FSM, round-robin pointer and sticky error next-state.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        err_d   = err_q;
        case (state_q)
            ARB_IDLE: begin
                if (s_cmd_valid && !s_cmd_ready) begin
                    state_d = ARB_LOCK;
                    grant_d = grant;
                end
            end
            ARB_LOCK: begin
                if (cmd_hs) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
        if (cmd_hs)                    rr_d  = ~grant;
        if (s_rsp_valid && fifo_empty) err_d = 1'b1;
    end

    // Control registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            grant_q <= REQ_M0;
            rr_q    <= REQ_M0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
        end
    end

    // FIFO empty flag must agree with its occupancy count.
    always_ff @(posedge clk) begin
        if (!rst) assert (fifo_empty == (id_count == '0));
    end

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Self-checking bench for dtcm_arbiter: scenario tasks with a scoreboard of
// expected grant order and response routing.
module tb_dtcm_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_cmd_valid, m0_cmd_ready, m0_cmd_read;
    logic [AW-1:0] m0_cmd_addr;
    logic [DW-1:0] m0_cmd_wdata;
    logic [MW-1:0] m0_cmd_wmask;
    logic          m0_rsp_valid, m0_rsp_ready;
    logic [DW-1:0] m0_rsp_rdata;
    logic          m1_cmd_valid, m1_cmd_ready, m1_cmd_read;
    logic [AW-1:0] m1_cmd_addr;
    logic [DW-1:0] m1_cmd_wdata;
    logic [MW-1:0] m1_cmd_wmask;
    logic          m1_rsp_valid, m1_rsp_ready;
    logic [DW-1:0] m1_rsp_rdata;
    logic          s_cmd_valid, s_cmd_ready, s_cmd_read;
    logic [AW-1:0] s_cmd_addr;
    logic [DW-1:0] s_cmd_wdata;
    logic [MW-1:0] s_cmd_wmask;
    logic          s_rsp_valid, s_rsp_ready;
    logic [DW-1:0] s_rsp_rdata;
    logic          rsp_err;

    int checks = 0;
    int fails  = 0;

    bit exp_gnt_q[$];   // expected winner of each command handshake
    bit exp_id_q[$];    // expected owner of each outstanding response

    always #5 clk = ~clk;

    dtcm_arbiter #(.AW(AW), .DW(DW), .MW(MW), .OUTS_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_read(m0_cmd_read),
        .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wmask(m0_cmd_wmask),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_read(m1_cmd_read),
        .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wmask(m1_cmd_wmask),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rsp_rdata(m1_rsp_rdata),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_read(s_cmd_read),
        .s_cmd_addr(s_cmd_addr), .s_cmd_wdata(s_cmd_wdata), .s_cmd_wmask(s_cmd_wmask),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rsp_rdata(s_rsp_rdata),
        .rsp_err(rsp_err)
    );

    task automatic idle_inputs();
        m0_cmd_valid = 0; m0_cmd_read = 0; m0_cmd_addr = '0; m0_cmd_wdata = '0; m0_cmd_wmask = '0;
        m1_cmd_valid = 0; m1_cmd_read = 0; m1_cmd_addr = '0; m1_cmd_wdata = '0; m1_cmd_wmask = '0;
        m0_rsp_ready = 0; m1_rsp_ready = 0;
        s_cmd_ready = 0; s_rsp_valid = 0; s_rsp_rdata = '0;
    endtask

    // Leaves the bench 1 time unit after the edge that applied reset.
    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 0;
        exp_gnt_q.delete();
        exp_id_q.delete();
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    // Answer every outstanding command and verify each is routed to its owner.
    task automatic drain_responses();
        int  cyc = 0;
        bit  e;
        logic [DW-1:0] rd;
        m0_rsp_ready = 1; m1_rsp_ready = 1;
        while (exp_id_q.size() > 0 && cyc < 20) begin
            rd = $urandom;
            s_rsp_valid = 1; s_rsp_rdata = rd;
            @(negedge clk);
            if (s_rsp_ready) begin
                e = exp_id_q.pop_front();
                checks++;
                if (m1_rsp_valid !== e || m0_rsp_valid !== !e) begin
                    fails++;
                    $display("FAIL drain_route: m0_rsp_valid=%b m1_rsp_valid=%b, want owner m%0d", m0_rsp_valid, m1_rsp_valid, e);
                end
                checks++;
                if ((e ? m1_rsp_rdata : m0_rsp_rdata) !== rd) begin
                    fails++;
                    $display("FAIL drain_rdata: got %h want %h", e ? m1_rsp_rdata : m0_rsp_rdata, rd);
                end
            end
            next_cycle();
            cyc++;
        end
        s_rsp_valid = 0;
        checks++;
        if (exp_id_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d responses still pending, want 0", exp_id_q.size());
            exp_id_q.delete();
        end
        @(negedge clk);
        checks++;
        if (int'(dut.u_id_fifo.count_o) != 0) begin
            fails++;
            $display("FAIL drain_count: count=%0d want 0", dut.u_id_fifo.count_o);
        end
        next_cycle();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({m0_cmd_ready, m1_cmd_ready, s_cmd_valid, m0_rsp_valid, m1_rsp_valid, s_rsp_ready} !== 6'b0) begin
            fails++;
            $display("FAIL reset_handshake: valid/ready=%b want 000000",
                     {m0_cmd_ready, m1_cmd_ready, s_cmd_valid, m0_rsp_valid, m1_rsp_valid, s_rsp_ready});
        end
        checks++;
        if (rsp_err !== 1'b0) begin fails++; $display("FAIL reset_err: rsp_err=%b want 0", rsp_err); end
        checks++;
        if (int'(dut.u_id_fifo.count_o) != 0 || dut.state_q !== 1'b0 || dut.rr_q !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: count=%0d state=%b rr=%b want 0/0/0", dut.u_id_fifo.count_o, dut.state_q, dut.rr_q);
        end
        next_cycle();
    endtask

    task automatic test_single();
        bit e;
        do_reset();
        m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = 16'h0010; s_cmd_ready = 1;
        @(negedge clk);
        checks++;
        if (s_cmd_valid !== 1'b1 || s_cmd_addr !== 16'h0010 || s_cmd_read !== 1'b1 || m0_cmd_ready !== 1'b1 || m1_cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL single_cmd: valid=%b addr=%h read=%b rdy0=%b rdy1=%b want 1/0010/1/1/0",
                     s_cmd_valid, s_cmd_addr, s_cmd_read, m0_cmd_ready, m1_cmd_ready);
        end
        exp_id_q.push_back(1'b0);
        next_cycle();
        m0_cmd_valid = 0; s_cmd_ready = 0;
        s_rsp_valid = 1; s_rsp_rdata = 32'hDEADBEEF; m0_rsp_ready = 1;
        @(negedge clk);
        checks++;
        if (int'(dut.u_id_fifo.count_o) != 1) begin
            fails++; $display("FAIL single_count1: count=%0d want 1", dut.u_id_fifo.count_o);
        end
        e = exp_id_q.pop_front();
        checks++;
        if (m0_rsp_valid !== !e || m1_rsp_valid !== e || m0_rsp_rdata !== 32'hDEADBEEF || s_rsp_ready !== 1'b1) begin
            fails++;
            $display("FAIL single_rsp: v0=%b v1=%b rdata=%h s_rdy=%b want 1/0/deadbeef/1",
                     m0_rsp_valid, m1_rsp_valid, m0_rsp_rdata, s_rsp_ready);
        end
        next_cycle();
        s_rsp_valid = 0;
        @(negedge clk);
        checks++;
        if (int'(dut.u_id_fifo.count_o) != 0 || rsp_err !== 1'b0) begin
            fails++; $display("FAIL single_count0: count=%0d err=%b want 0/0", dut.u_id_fifo.count_o, rsp_err);
        end
        next_cycle();
    endtask

    task automatic test_fairness();
        int hs = 0;
        int cyc = 0;
        bit eg, e;
        logic [DW-1:0] rd = 32'h1000_0000;
        do_reset();
        for (int i = 0; i < 6; i++) exp_gnt_q.push_back(1'(i % 2));
        m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = 16'h0100;
        m1_cmd_valid = 1; m1_cmd_read = 0; m1_cmd_addr = 16'h0200;
        m1_cmd_wdata = 32'h0BAD_F00D; m1_cmd_wmask = 4'hF;
        s_cmd_ready = 1; m0_rsp_ready = 1; m1_rsp_ready = 1;
        while (hs < 6 && cyc < 40) begin
            s_rsp_valid = (exp_id_q.size() > 0); s_rsp_rdata = rd;
            @(negedge clk);
            if (s_rsp_valid && s_rsp_ready) begin
                e = exp_id_q.pop_front();
                checks++;
                if (m1_rsp_valid !== e || m0_rsp_valid !== !e || (e ? m1_rsp_rdata : m0_rsp_rdata) !== rd) begin
                    fails++;
                    $display("FAIL fair_rsp: v0=%b v1=%b want owner m%0d data %h", m0_rsp_valid, m1_rsp_valid, e, rd);
                end
                rd++;
            end
            if (s_cmd_valid && s_cmd_ready) begin
                eg = exp_gnt_q.pop_front();
                checks++;
                if (m1_cmd_ready !== eg || m0_cmd_ready !== !eg || s_cmd_addr !== (eg ? 16'h0200 : 16'h0100)) begin
                    fails++;
                    $display("FAIL fair_grant%0d: rdy0=%b rdy1=%b addr=%h want winner m%0d", hs, m0_cmd_ready, m1_cmd_ready, s_cmd_addr, eg);
                end
                exp_id_q.push_back(eg);
                hs++;
            end
            next_cycle();
            cyc++;
        end
        checks++;
        if (hs != 6) begin fails++; $display("FAIL fair_timeout: %0d handshakes want 6", hs); end
        m0_cmd_valid = 0; m1_cmd_valid = 0;
        drain_responses();
    endtask

    task automatic test_lock();
        do_reset();
        m1_cmd_valid = 1; m1_cmd_read = 1; m1_cmd_addr = 16'h0300; s_cmd_ready = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (s_cmd_addr !== 16'h0300 || s_cmd_valid !== 1'b1 || m0_cmd_ready !== 1'b0 || m1_cmd_ready !== 1'b0) begin
                fails++;
                $display("FAIL lock_hold%0d: addr=%h valid=%b rdy0=%b rdy1=%b want 0300/1/0/0", c, s_cmd_addr, s_cmd_valid, m0_cmd_ready, m1_cmd_ready);
            end
            next_cycle();
            m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = 16'h0040;
        end
        s_cmd_ready = 1;
        @(negedge clk);
        checks++;
        if (s_cmd_addr !== 16'h0300 || m1_cmd_ready !== 1'b1 || m0_cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL lock_release: addr=%h rdy0=%b rdy1=%b want 0300/0/1", s_cmd_addr, m0_cmd_ready, m1_cmd_ready);
        end
        exp_id_q.push_back(1'b1);
        next_cycle();
        m1_cmd_valid = 0;
        @(negedge clk);
        checks++;
        if (s_cmd_addr !== 16'h0040 || m0_cmd_ready !== 1'b1) begin
            fails++; $display("FAIL lock_next: addr=%h rdy0=%b want 0040/1", s_cmd_addr, m0_cmd_ready);
        end
        exp_id_q.push_back(1'b0);
        next_cycle();
        m0_cmd_valid = 0; s_cmd_ready = 0;
        drain_responses();
    endtask

    task automatic test_full_block();
        bit e;
        do_reset();
        s_cmd_ready = 1; m0_rsp_ready = 1; m1_rsp_ready = 1;
        m0_cmd_valid = 1; m0_cmd_read = 1; m0_cmd_addr = 16'h0010;
        @(negedge clk);
        checks++;
        if (m0_cmd_ready !== 1'b1) begin fails++; $display("FAIL full_cmd1: rdy0=%b want 1", m0_cmd_ready); end
        exp_id_q.push_back(1'b0);
        next_cycle();
        m0_cmd_valid = 0; m1_cmd_valid = 1; m1_cmd_read = 1; m1_cmd_addr = 16'h0020;
        @(negedge clk);
        checks++;
        if (m1_cmd_ready !== 1'b1) begin fails++; $display("FAIL full_cmd2: rdy1=%b want 1", m1_cmd_ready); end
        exp_id_q.push_back(1'b1);
        next_cycle();
        m1_cmd_valid = 0; m0_cmd_valid = 1; m0_cmd_addr = 16'h0030;
        s_rsp_valid = 1; s_rsp_rdata = 32'hA5A5_0001;
        @(negedge clk);
        checks++;
        if (s_cmd_valid !== 1'b0 || m0_cmd_ready !== 1'b0) begin
            fails++; $display("FAIL full_block: s_valid=%b rdy0=%b want 0/0", s_cmd_valid, m0_cmd_ready);
        end
        e = exp_id_q.pop_front();
        checks++;
        if (m0_rsp_valid !== !e || m1_rsp_valid !== e || s_rsp_ready !== 1'b1) begin
            fails++; $display("FAIL full_rsp1: v0=%b v1=%b s_rdy=%b want owner m%0d", m0_rsp_valid, m1_rsp_valid, s_rsp_ready, e);
        end
        next_cycle();
        s_rsp_valid = 0;
        @(negedge clk);
        checks++;
        if (s_cmd_valid !== 1'b1 || m0_cmd_ready !== 1'b1 || s_cmd_addr !== 16'h0030) begin
            fails++; $display("FAIL full_unblock: s_valid=%b rdy0=%b addr=%h want 1/1/0030", s_cmd_valid, m0_cmd_ready, s_cmd_addr);
        end
        exp_id_q.push_back(1'b0);
        next_cycle();
        m0_cmd_valid = 0; s_cmd_ready = 0;
        drain_responses();
    endtask

    task automatic test_rsp_backpressure();
        bit e;
        do_reset();
        m1_cmd_valid = 1; m1_cmd_read = 1; m1_cmd_addr = 16'h0400; s_cmd_ready = 1;
        @(negedge clk);
        checks++;
        if (m1_cmd_ready !== 1'b1) begin fails++; $display("FAIL bp_cmd: rdy1=%b want 1", m1_cmd_ready); end
        exp_id_q.push_back(1'b1);
        next_cycle();
        m1_cmd_valid = 0; s_cmd_ready = 0;
        s_rsp_valid = 1; s_rsp_rdata = 32'hCAFE_F00D; m1_rsp_ready = 0; m0_rsp_ready = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (m1_rsp_valid !== 1'b1 || m0_rsp_valid !== 1'b0 || s_rsp_ready !== 1'b0 || int'(dut.u_id_fifo.count_o) != 1) begin
                fails++;
                $display("FAIL bp_stall%0d: v1=%b v0=%b s_rdy=%b count=%0d want 1/0/0/1", c, m1_rsp_valid, m0_rsp_valid, s_rsp_ready, dut.u_id_fifo.count_o);
            end
            next_cycle();
        end
        m1_rsp_ready = 1;
        @(negedge clk);
        e = exp_id_q.pop_front();
        checks++;
        if (s_rsp_ready !== 1'b1 || m1_rsp_valid !== e || m1_rsp_rdata !== 32'hCAFE_F00D) begin
            fails++; $display("FAIL bp_pop: s_rdy=%b v1=%b rdata=%h want 1/1/cafef00d", s_rsp_ready, m1_rsp_valid, m1_rsp_rdata);
        end
        next_cycle();
        s_rsp_valid = 0;
        @(negedge clk);
        checks++;
        if (int'(dut.u_id_fifo.count_o) != 0 || rsp_err !== 1'b0) begin
            fails++; $display("FAIL bp_count: count=%0d err=%b want 0/0", dut.u_id_fifo.count_o, rsp_err);
        end
        next_cycle();
    endtask

    task automatic test_err_and_reset();
        do_reset();
        s_rsp_valid = 1; s_rsp_rdata = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (s_rsp_ready !== 1'b1 || m0_rsp_valid !== 1'b0 || m1_rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            fails++; $display("FAIL err_drop: s_rdy=%b v0=%b v1=%b err=%b want 1/0/0/0", s_rsp_ready, m0_rsp_valid, m1_rsp_valid, rsp_err);
        end
        next_cycle();
        s_rsp_valid = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_err !== 1'b1) begin fails++; $display("FAIL err_sticky%0d: rsp_err=%b want 1", c, rsp_err); end
            next_cycle();
        end
        m0_cmd_valid = 1; m0_cmd_read = 0; m0_cmd_addr = 16'h0050; s_cmd_ready = 1;
        @(negedge clk);
        checks++;
        if (m0_cmd_ready !== 1'b1) begin fails++; $display("FAIL err_cmd: rdy0=%b want 1", m0_cmd_ready); end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (int'(dut.u_id_fifo.count_o) != 1 || dut.rr_q !== 1'b1) begin
            fails++; $display("FAIL err_pre_reset: count=%0d rr=%b want 1/1", dut.u_id_fifo.count_o, dut.rr_q);
        end
        rst = 1;
        next_cycle();
        rst = 0;
        @(negedge clk);
        checks++;
        if (int'(dut.u_id_fifo.count_o) != 0 || rsp_err !== 1'b0 || dut.state_q !== 1'b0 || dut.rr_q !== 1'b0) begin
            fails++;
            $display("FAIL err_reset: count=%0d err=%b state=%b rr=%b want 0/0/0/0", dut.u_id_fifo.count_o, rsp_err, dut.state_q, dut.rr_q);
        end
        checks++;
        if ({m0_cmd_ready, m1_cmd_ready, s_cmd_valid, m0_rsp_valid, m1_rsp_valid, s_rsp_ready} !== 6'b0) begin
            fails++;
            $display("FAIL err_reset_outputs: valid/ready=%b want 000000",
                     {m0_cmd_ready, m1_cmd_ready, s_cmd_valid, m0_rsp_valid, m1_rsp_valid, s_rsp_ready});
        end
        next_cycle();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_single();
        test_fairness();
        test_lock();
        test_full_block();
        test_rsp_backpressure();
        test_err_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/dtcm_arbiter.md
Name: dtcm_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single DTCM command/response channel (dtcm_ctrl) between the core LSU (port m0) and a secondary requester such as a DMA or debug engine (port m1).
- Sits between the requesters and dtcm_ctrl.
- Routes in-order responses back to the originating requester using an ID FIFO of outstanding transactions.

Parameters:
- AW, 16, DTCM byte address width (matches DTCM_ADDR_WIDTH).
- DW, 32, data width (matches DTCM_RAM_DW).
- MW, 4, write byte-mask width (DW/8).
- OUTS_DEPTH, 2, maximum outstanding commands tracked (power of 2, at least 1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- m0_cmd_valid / m1_cmd_valid  in  1  command valid per requester
- m0_cmd_ready / m1_cmd_ready  out  1  command accepted
- m0_cmd_read / m1_cmd_read  in  1  1 = read, 0 = write
- m0_cmd_addr / m1_cmd_addr  in  AW  byte address
- m0_cmd_wdata / m1_cmd_wdata  in  DW  write data
- m0_cmd_wmask / m1_cmd_wmask  in  MW  byte write mask
- m0_rsp_valid / m1_rsp_valid  out  1  response valid
- m0_rsp_ready / m1_rsp_ready  in  1  requester accepts response
- m0_rsp_rdata / m1_rsp_rdata  out  DW  read data
- s_cmd_valid  out  1  to dtcm_ctrl
- s_cmd_ready  in  1
- s_cmd_read  out  1
- s_cmd_addr  out  AW
- s_cmd_wdata  out  DW
- s_cmd_wmask  out  MW
- s_rsp_valid  in  1  from dtcm_ctrl
- s_rsp_ready  out  1
- s_rsp_rdata  in  DW
- rsp_err  out  1  sticky: response arrived with no outstanding command

Behaviour:
- Reset (rst=1 at a clk edge):
  - State returns to IDLE and the round-robin pointer is set to m0.
  - ID FIFO is emptied and its count set to 0; rsp_err is cleared.
  - All valid/ready outputs are 0 in the cycle after reset. Reset mid-transaction drops all outstanding IDs.
- Arbiter FSM, two states:
  - IDLE: no grant held. The combinational grant goes to the requester selected by the round-robin pointer when it is valid, else to the other requester if valid. The granted requester's cmd fields drive s_cmd_*.
    - If s_cmd_ready=1 in the same cycle: handshake completes and the FSM stays in IDLE.
    - If s_cmd_ready=0: the FSM moves to LOCK with the grant registered.
  - LOCK: grant is held fixed, with no re-arbitration even if the other requester becomes valid. The requester must keep its cmd stable. Return to IDLE on s_cmd_valid && s_cmd_ready.
- Round-robin pointer: after every command handshake, the pointer moves to the requester that did not win. When only one requester is valid, it wins back-to-back every cycle.
- Command blocking:
  - When the ID FIFO is full (count == OUTS_DEPTH), s_cmd_valid=0 and both mN_cmd_ready=0.
  - A simultaneous pop does not unblock push in the same cycle. This avoids a combinational rsp-to-cmd path; the cost is a one-cycle bubble.
- Ready routing: mN_cmd_ready = s_cmd_ready && grant==N && !full. The non-granted requester sees ready=0.
- ID FIFO:
  - Push the 1-bit requester ID on each s_cmd handshake.
  - Pop on each s_rsp handshake.
  - Pointers wrap modulo OUTS_DEPTH.
  - Count is updated as +1, -1 or 0 on simultaneous push and pop, including when the FIFO is full and popping.
- Response routing:
  - head = FIFO head ID.
  - m{head}_rsp_valid = s_rsp_valid && !empty; the other requester's rsp_valid = 0.
  - s_rsp_ready = m{head}_rsp_ready when not empty.
  - Both mN_rsp_rdata = s_rsp_rdata (unqualified).
- Empty-FIFO response: if s_rsp_valid=1 while the FIFO is empty:
  - s_rsp_ready=1, so the response is dropped.
  - rsp_err is set and held until reset.
- Latency: zero added cycles on the cmd path (combinational pass-through) and on the rsp path. Throughput is 1 command per cycle when the FIFO is not full.

Decomposition:
- Shared defines header holds DTCM_ADDR_WIDTH, DTCM_RAM_DW, DTCM_RAM_MW and the FSM state encodings ARB_IDLE and ARB_LOCK.
- One natural sub-module: arb_id_fifo, a parameterised synchronous FIFO (width 1, depth OUTS_DEPTH) with push, pop, head, full, empty and count outputs.

Test Plan:
1. Single requester: m0 issues read at 0x0010 with s_cmd_ready=1, and dtcm_ctrl returns 0xDEADBEEF next cycle -> m0_rsp_valid=1 with rdata 0xDEADBEEF, m1_rsp_valid stays 0, FIFO count 1 then 0.
2. Contention fairness: m0 and m1 hold valid continuously for 6 handshakes after reset -> grant order m0, m1, m0, m1, m0, m1.
3. Lock on backpressure: m1 granted with s_cmd_ready=0 for 3 cycles while m0 asserts valid -> s_cmd_addr stays at m1's address, m0_cmd_ready=0, m1 handshakes on cycle 4.
4. Full blocking (OUTS_DEPTH=2): two accepted cmds with no responses -> third cmd sees s_cmd_valid=0. After one rsp handshake, it is accepted the next cycle. Responses route to IDs in issue order.
5. Response backpressure: rsp for m1 with m1_rsp_ready=0 for 2 cycles -> s_rsp_ready=0, FIFO head unchanged; pop occurs on the ready cycle.
6. Error and reset: s_rsp_valid=1 with the FIFO empty -> rsp_err=1 and stays 1. Assert rst with 1 outstanding -> next cycle count=0, rsp_err=0, state IDLE, pointer at m0.
